// File: rtl/load_store_unit_if.sv
// load_store_unit_if: request/response and memory-bus signals of the load/store unit.
// Handshake: a request transfers on a rising clk edge where req_valid & req_ready;
// the requester holds req_* stable while req_valid is high and not yet accepted.
// 'slave' is the unit's view; 'master' is the datapath + memory side.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        done;
  logic        err;
  logic [31:0] rdata;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    input  mem_read_data,
    output req_ready, done, err, rdata,
    output mem_read, mem_write, mem_address, mem_write_data
  );

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    output mem_read_data,
    input  req_ready, done, err, rdata,
    input  mem_read, mem_write, mem_address, mem_write_data
  );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: initiator between datapath and a word-organised single-port memory.
// Byte/halfword/word loads with sign/zero extension; sub-word stores via read-modify-write.
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned halfword/word accesses raise err
// instead of being aligned down to the access size.
// o_dbg_state exposes the FSM state (0 IDLE, 1 READ, 2 WRITE, 3 DONE).
module load_store_unit #(
  parameter int MEM_WORDS = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  load_store_unit_if.slave      bus,
  output logic [1:0]            o_dbg_state
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [32:0] ADDR_LIMIT = 33'(MEM_WORDS * 4);

  logic [1:0]  r_state;
  logic [31:0] r_addr;
  logic [1:0]  r_size;
  logic        r_write;
  logic        r_unsigned;
  logic [31:0] r_wdata;
  logic [31:0] r_wword;
  logic [31:0] r_rdata;
  logic        r_err;

  logic        w_is_byte;
  logic        w_is_half;
  logic        w_oor;
  logic        w_bad;
  logic [31:0] w_addr_al;
  logic        w_r_byte;
  logic        w_r_half;
  logic [7:0]  w_lane_b;
  logic [15:0] w_lane_h;
  logic [31:0] w_load_val;
  logic [31:0] w_merged;
`ifdef LSU_MISALIGN_TRAP_EN
  logic        w_misalign;
`endif

  // Classify the incoming request: size decode, range/alignment check, aligned address.
  always_comb begin
    w_is_byte = (bus.req_size == 2'b00);
    w_is_half = (bus.req_size == 2'b01);
    w_oor     = ({1'b0, bus.req_addr} >= ADDR_LIMIT);
`ifdef LSU_MISALIGN_TRAP_EN
    w_misalign = (w_is_half & bus.req_addr[0]) |
                 (!w_is_byte && !w_is_half && (bus.req_addr[1:0] != 2'b00));
    w_bad      = w_oor | w_misalign;
`else
    w_bad      = w_oor;
`endif
    // Aligning down is a no-op for any access that passes the trap check.
    if (w_is_half)      w_addr_al = {bus.req_addr[31:1], 1'b0};
    else if (w_is_byte) w_addr_al = bus.req_addr;
    else                w_addr_al = {bus.req_addr[31:2], 2'b00};
  end

  // Lane extraction, extension and merge on the word returned during READ.
  always_comb begin
    w_r_byte = (r_size == 2'b00);
    w_r_half = (r_size == 2'b01);
    w_lane_b = bus.mem_read_data[{r_addr[1:0], 3'b000} +: 8];
    w_lane_h = bus.mem_read_data[{r_addr[1], 4'b0000} +: 16];
    if (w_r_byte)
      w_load_val = r_unsigned ? {24'd0, w_lane_b} : {{24{w_lane_b[7]}}, w_lane_b};
    else if (w_r_half)
      w_load_val = r_unsigned ? {16'd0, w_lane_h} : {{16{w_lane_h[15]}}, w_lane_h};
    else
      w_load_val = bus.mem_read_data;
    w_merged = bus.mem_read_data;
    if (w_r_byte)      w_merged[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
    else if (w_r_half) w_merged[{r_addr[1], 4'b0000} +: 16] = r_wdata[15:0];
    else               w_merged = r_wdata;
  end

  // FSM and latched request fields; reset abandons any access in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_addr     <= 32'd0;
      r_size     <= 2'b00;
      r_write    <= 1'b0;
      r_unsigned <= 1'b0;
      r_wdata    <= 32'd0;
      r_wword    <= 32'd0;
      r_rdata    <= 32'd0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.req_valid) begin
            r_addr     <= w_addr_al;
            r_size     <= bus.req_size;
            r_write    <= bus.req_write;
            r_unsigned <= bus.req_unsigned;
            r_wdata    <= bus.req_wdata;
            r_rdata    <= 32'd0;
            if (w_bad) begin
              r_err   <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_err <= 1'b0;
              if (!bus.req_write || w_is_byte || w_is_half) begin
                r_state <= S_READ;
              end else begin
                r_wword <= bus.req_wdata;
                r_state <= S_WRITE;
              end
            end
          end
        end
        S_READ: begin
          if (r_write) begin
            r_wword <= w_merged;
            r_state <= S_WRITE;
          end else begin
            r_rdata <= w_load_val;
            r_state <= S_DONE;
          end
        end
        S_WRITE: r_state <= S_DONE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready      = (r_state == S_IDLE);
  assign bus.done           = (r_state == S_DONE);
  assign bus.err            = (r_state == S_DONE) & r_err;
  assign bus.rdata          = r_rdata;
  assign bus.mem_read       = (r_state == S_READ);
  assign bus.mem_write      = (r_state == S_WRITE);
  assign bus.mem_address    = {r_addr[31:2], 2'b00};
  assign bus.mem_write_data = r_wword;
  assign o_dbg_state        = r_state;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed plus random transactions against a byte-array
// reference model of memory and the access timing rules.
module tb_load_store_unit;
  localparam int MEM_WORDS = 64;
  localparam int AW        = $clog2(MEM_WORDS);
`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] dbg_state;
  logic       mem_init;
  logic [31:0] salt;

  load_store_unit_if bus();

  load_store_unit #(.MEM_WORDS(MEM_WORDS)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus.slave),
    .o_dbg_state (dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  // Attached memory: combinational read, write at clock edge.
  logic [31:0] mem [0:MEM_WORDS-1];
  logic [7:0]  ref_mem [0:MEM_WORDS*4-1];

  function automatic logic [31:0] init_word(input int i);
    return (32'(i) * 32'h9E3779B9) ^ salt;
  endfunction

  always_comb bus.mem_read_data = mem[bus.mem_address[AW+1:2]];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < MEM_WORDS; i++) mem[i] = init_word(i);
    end else if (bus.mem_write) begin
      mem[bus.mem_address[AW+1:2]] = bus.mem_write_data;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model
  function automatic int nbytes(input logic [1:0] size);
    return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit model_err(input logic [1:0] size, input logic [31:0] addr);
    if (addr >= 32'(MEM_WORDS * 4)) return 1'b1;
    if (TRAP && (addr % 32'(nbytes(size)) != 0)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    int b;
    b = int'({a[31:2], 2'b00});
    return {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
  endfunction

  // One transaction with requester holding req_valid until done.
  task automatic run_txn(input string tag, input bit wr, input logic [1:0] size,
                         input bit uns, input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rdata_o);
    int n, b, k, done_cyc;
    bit e_err, both;
    logic [31:0] base, e_rdata, e_wdata, got_wdata, got_addr, got_rdata, got_err;
    logic [7:0] e_rd, e_wr, rd_mask, wr_mask;
    int e_done;
    n = nbytes(size);
    e_err = model_err(size, addr);
    base = addr - (addr % 32'(n));
    e_rd = 8'd0; e_wr = 8'd0; e_rdata = 32'd0; e_wdata = 32'd0;
    if (e_err)      e_done = 1;
    else if (!wr)   begin e_rd = 8'b0000_0010; e_done = 2; end
    else if (n == 4) begin e_wr = 8'b0000_0010; e_done = 2; end
    else            begin e_rd = 8'b0000_0010; e_wr = 8'b0000_0100; e_done = 3; end
    if (!e_err) begin
      b = int'(base);
      if (wr) begin
        for (int i = 0; i < n; i++) ref_mem[b+i] = wdata[8*i +: 8];
        e_wdata = ref_word(base);
      end else begin
        for (int i = 0; i < n; i++) e_rdata = e_rdata | (32'(ref_mem[b+i]) << (8*i));
        if (!uns && n < 4 && e_rdata[8*n-1]) e_rdata = e_rdata | (32'hFFFF_FFFF << (8*n));
      end
    end
    @(negedge clk);
    bus.req_write = wr; bus.req_size = size; bus.req_unsigned = uns;
    bus.req_addr = addr; bus.req_wdata = wdata; bus.req_valid = 1'b1;
    k = 0;
    while (!bus.req_ready && k < 10) begin @(negedge clk); k++; end
    check({tag, "_ready"}, 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    rd_mask = 8'd0; wr_mask = 8'd0; done_cyc = 0; both = 1'b0;
    got_wdata = 32'd0; got_addr = {base[31:2], 2'b00}; got_rdata = 32'd0; got_err = 32'd0;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (bus.mem_read) rd_mask[c] = 1'b1;
      if (bus.mem_write) begin wr_mask[c] = 1'b1; got_wdata = bus.mem_write_data; end
      if (bus.mem_read || bus.mem_write) got_addr = bus.mem_address;
      if (bus.mem_read && bus.mem_write) both = 1'b1;
      if (bus.done) begin
        done_cyc = c; got_err = 32'(bus.err); got_rdata = bus.rdata;
        break;
      end
    end
    bus.req_valid = 1'b0;
    check({tag, "_done_cycle"}, 32'(done_cyc), 32'(e_done));
    check({tag, "_err"}, got_err, 32'(e_err));
    check({tag, "_rd_cycles"}, 32'(rd_mask), 32'(e_rd));
    check({tag, "_wr_cycles"}, 32'(wr_mask), 32'(e_wr));
    check({tag, "_one_strobe"}, 32'(both), 32'd0);
    if (!e_err) check({tag, "_mem_addr"}, got_addr, {base[31:2], 2'b00});
    if (!e_err && wr) check({tag, "_wdata"}, got_wdata, e_wdata);
    if (!wr) check({tag, "_rdata"}, got_rdata, e_rdata);
    rdata_o = got_rdata;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r, old_w;
    logic [31:0] ra;
    // Reset and memory initialisation
    reset = 1'b1; mem_init = 1'b1; salt = $urandom;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'b00;
    bus.req_unsigned = 1'b0; bus.req_addr = 32'd0; bus.req_wdata = 32'd0;
    for (int i = 0; i < MEM_WORDS; i++)
      for (int j = 0; j < 4; j++) ref_mem[4*i+j] = init_word(i)[8*j +: 8];
    #12;
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    check("rst_rdata", bus.rdata, 32'd0);
    check("rst_mem_read", 32'(bus.mem_read), 32'd0);
    check("rst_mem_write", 32'(bus.mem_write), 32'd0);
    check("rst_mem_address", bus.mem_address, 32'd0);
    check("rst_mem_wdata", bus.mem_write_data, 32'd0);
    @(negedge clk); mem_init = 1'b0; reset = 1'b0;

    // Directed steps
    run_txn("st_w_10", 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, r);
    run_txn("ld_w_10", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, r);
    check("ld_w_10_const", r, 32'hDEADBEEF);
    run_txn("st_w_20", 1'b1, 2'd2, 1'b0, 32'h20, 32'h11223344, r);
    run_txn("st_b_21", 1'b1, 2'd0, 1'b0, 32'h21, 32'h5A5A5AAB, r);
    check("st_b_21_mem", mem[8], 32'h1122AB44);
    run_txn("ld_bs_21", 1'b0, 2'd0, 1'b0, 32'h21, 32'h0, r);
    check("ld_bs_21_const", r, 32'hFFFFFFAB);
    run_txn("ld_bu_21", 1'b0, 2'd0, 1'b1, 32'h21, 32'h0, r);
    check("ld_bu_21_const", r, 32'h000000AB);
    run_txn("ld_hs_22", 1'b0, 2'd1, 1'b0, 32'h22, 32'h0, r);
    check("ld_hs_22_const", r, 32'h00001122);
    run_txn("st_h_22", 1'b1, 2'd1, 1'b0, 32'h22, 32'hFFFF8001, r);
    run_txn("ld_hs_22b", 1'b0, 2'd1, 1'b0, 32'h22, 32'h0, r);
    run_txn("ld_h_13", 1'b0, 2'd1, 1'b0, 32'h13, 32'h0, r);
    run_txn("ld_w_13", 1'b0, 2'd3, 1'b1, 32'h13, 32'h0, r);
    run_txn("ld_w_100", 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, r);
    check("ld_w_100_rdata0", r, 32'd0);
    run_txn("st_b_100", 1'b1, 2'd0, 1'b0, 32'h100, 32'hFF, r);
    run_txn("st_w_fc", 1'b1, 2'd2, 1'b0, 32'hFC, 32'hCAFEF00D, r);
    run_txn("ld_bs_ff", 1'b0, 2'd0, 1'b0, 32'hFF, 32'h0, r);
    run_txn("ld_hi_addr", 1'b0, 2'd0, 1'b0, 32'hFFFF_FFFC, 32'h0, r);

    // Random traffic
    for (int t = 0; t < 40; t++) begin
      ra = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(256, 300)) : 32'($urandom_range(0, 255));
      run_txn("rand", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), ra, $urandom, r);
    end

    // Reset during READ of a sub-word store
    old_w = ref_word(32'h30);
    @(negedge clk);
    bus.req_write = 1'b1; bus.req_size = 2'd0; bus.req_unsigned = 1'b0;
    bus.req_addr = 32'h31; bus.req_wdata = ~old_w; bus.req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rmw_rst_in_read", 32'(bus.mem_read), 32'd1);
    #1 reset = 1'b1;
    #1;
    check("rmw_rst_read_drop", 32'(bus.mem_read), 32'd0);
    check("rmw_rst_write_drop", 32'(bus.mem_write), 32'd0);
    check("rmw_rst_ready", 32'(bus.req_ready), 32'd1);
    check("rmw_rst_done", 32'(bus.done), 32'd0);
    bus.req_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rmw_rst_ready_after", 32'(bus.req_ready), 32'd1);
    check("rmw_rst_mem_unchanged", mem[12], old_w);
    run_txn("ld_w_30_after_rst", 1'b0, 2'd2, 1'b0, 32'h30, 32'h0, r);

    // Whole-memory comparison against the reference
    for (int i = 0; i < MEM_WORDS; i++) check("mem_sweep", mem[i], ref_word(32'(4*i)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

- Initiator-side load/store unit between the datapath and the single-port, word-organised data memory.
- Accepts one byte, halfword or word load/store request at a time and drives the memory's `mem_read`/`mem_write` strobes.
- Performs load sign/zero extension, and read-modify-write for sub-word stores, because the memory only writes full words.
- Reports completion with a one-cycle `done` pulse and flags misaligned or out-of-range accesses.

## Interface
Parameters:
- `MEM_WORDS`, 64: words in the attached memory; byte addresses ≥ `MEM_WORDS*4` are out of range.

Ports:
- `clk`  in  1  clock, all state on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `req_valid`  in  1  request present
- `req_ready`  out  1  unit idle, request accepted when `req_valid & req_ready`
- `req_write`  in  1  1 = store, 0 = load
- `req_size`  in  2  00 byte, 01 halfword, 10 word; 11 treated as word
- `req_unsigned`  in  1  loads: zero-extend (1) or sign-extend (0)
- `req_addr`  in  32  byte address
- `req_wdata`  in  32  store data, value in low bits
- `done`  out  1  one-cycle completion pulse
- `err`  out  1  valid with `done`: misaligned/out-of-range, no memory write performed
- `rdata`  out  32  load result, held until next accepted request
- `mem_read`  out  1  memory read strobe
- `mem_write`  out  1  memory write strobe
- `mem_address`  out  32  word-aligned byte address `{addr[31:2],2'b00}`
- `mem_write_data`  out  32  full word to write
- `mem_read_data`  in  32  combinational memory read data

## Operation
- States: IDLE, READ, WRITE, DONE.
- Request (addr, size, write, unsigned, wdata) latched on acceptance. All `mem_*` outputs derive from registered state/latched fields only; no combinational path from `req_*`.
- IDLE, accept:
  - bad access → DONE with err set.
  - load, or store with size≠word → READ.
  - word store → WRITE.
- READ: `mem_read=1`; `mem_read_data` captured at clock edge.
  - load → DONE with extracted, extended `rdata`.
  - store → WRITE with merged word.
- WRITE: `mem_write=1`, `mem_write_data` = merged word (word store: wdata) → DONE.
- DONE: `done=1` → IDLE.
- Lane select is little-endian:
  - byte lane = `addr[1:0]`
  - halfword lane = `addr[1]`
- Merge: captured word with the selected lane replaced by `wdata[7:0]` or `wdata[15:0]`; other lanes unchanged.
- Extension: byte/half loads sign- or zero-extended to 32 bits per latched `req_unsigned`.
- Out of range: `addr ≥ MEM_WORDS*4` is always an error. Loads with err leave `rdata` = 0.
- `req_ready=1` only in IDLE; `req_valid` in other states is ignored and must be held by the requester.

## Timing
- Acceptance edge = cycle 0; `done` asserts in the cycle listed:
  - load: READ cycle 1, `done` cycle 2.
  - word store: WRITE cycle 1 (memory writes at end of cycle 1), `done` cycle 2.
  - sub-word store: READ 1, WRITE 2, `done` cycle 3.
  - error: `done` and `err` cycle 1, no strobes.
- Back-to-back: new request accepted in the cycle after DONE (IDLE); at most one strobe active per cycle, never both.
- Reset, async, effective immediately, including mid-operation: state IDLE, `req_ready=1`, `done=0`, `err=0`, `rdata=0`, `mem_read=0`, `mem_write=0`, `mem_address=0`, `mem_write_data=0`. An interrupted RMW performs no write.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - halfword with `addr[0]=1`, or word with `addr[1:0]≠0`, is an error (err path, no access).
- Not defined:
  - misaligned addresses are silently aligned down to the access size (halfword clears bit 0, word clears bits 1:0), then processed normally.
  - only out-of-range raises `err`.

## Test plan
- Word store 0xDEADBEEF @0x10, then word load @0x10 → `mem_write` only in cycle 1; load `done` cycle 2, `rdata`=0xDEADBEEF, err=0.
- Memory word @0x20 = 0x11223344; byte store 0xAB @0x21 → READ then WRITE with `mem_write_data`=0x1122AB44, `done` cycle 3.
- Same word, signed byte load @0x21 → `rdata`=0xFFFFFFAB. Unsigned → 0x000000AB. Signed half @0x22 → 0x00001122.
- Halfword load @0x13: with `LSU_MISALIGN_TRAP_EN` → `done`+`err` in cycle 1, no strobes. Without → reads @0x12.
- Load @0x100 with `MEM_WORDS`=64 → `err=1`, `rdata`=0, no strobes. `req_valid` held during busy → exactly one access per acceptance.
- Assert `reset` during READ of a sub-word store → strobes drop immediately, no write occurs, memory word unchanged, `req_ready=1` after release.
